// File: rtl/bcd_disp_pkg.sv
// ----------------------------------------------------------------------------
// bcd_disp_pkg
// Shared definitions for the 3-digit multiplexed 7-segment display path:
//   - digit_e   : scan position (D0 = ones, D1 = tens, D2 = hundreds)
//   - SEG_*     : active-low segment patterns, bit order {g,f,e,d,c,b,a}
//   - lz_blank(): leading-zero blanking decision for one scan position
// ----------------------------------------------------------------------------
package bcd_disp_pkg;

    typedef enum logic [1:0] {
        D0 = 2'd0,
        D1 = 2'd1,
        D2 = 2'd2
    } digit_e;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;   // segment g only
    localparam logic [6:0] SEG_OFF  = 7'h7F;   // all segments dark

    // A digit is blanked only when it and every more significant digit are
    // zero. Zero is a valid nibble, so a dash (A-F) can never be blanked.
    // The ones digit always shows.
    function automatic logic lz_blank(input logic [3:0] hns,
                                      input logic [3:0] tens,
                                      input digit_e     digit_idx);
        logic blank;
        case (digit_idx)
            D2:      blank = (hns == 4'h0);
            D1:      blank = (hns == 4'h0) && (tens == 4'h0);
            default: blank = 1'b0;
        endcase
        return blank;
    endfunction

endpackage

// File: rtl/bcd_seg_scan_if.sv
// ----------------------------------------------------------------------------
// bcd_seg_scan_if
// Bundles the value input and the display pins of bcd_seg_scan.
//   bcd_in     [11:0] {hundreds, tens, ones} BCD value
//   bcd_valid         one-cycle capture strobe for bcd_in
//   seg_n      [6:0]  active-low segments {g,f,e,d,c,b,a}
//   dig_sel_n  [2:0]  active-low digit enables (bit0 ones .. bit2 hundreds)
//   frame_done        one-cycle pulse when the displayed value is refreshed
// master: the value producer / pin observer; slave: the display scanner.
// ----------------------------------------------------------------------------
interface bcd_seg_scan_if;

    logic [11:0] bcd_in;
    logic        bcd_valid;
    logic [6:0]  seg_n;
    logic [2:0]  dig_sel_n;
    logic        frame_done;

    modport master (
        output bcd_in,
        output bcd_valid,
        input  seg_n,
        input  dig_sel_n,
        input  frame_done
    );

    modport slave (
        input  bcd_in,
        input  bcd_valid,
        output seg_n,
        output dig_sel_n,
        output frame_done
    );

endinterface

// File: rtl/bcd_to_seg7.sv
// ----------------------------------------------------------------------------
// bcd_to_seg7
// Combinational BCD nibble to active-low 7-segment decoder. Nibbles A-F,
// which are not BCD, show a dash so bad data is visible on the display.
//   nibble_i [3:0] BCD digit
//   seg_n_o  [6:0] active-low segments {g,f,e,d,c,b,a}
// ----------------------------------------------------------------------------
module bcd_to_seg7
    import bcd_disp_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_n_o
);

    always_comb begin
        case (nibble_i)
            4'd0:    seg_n_o = SEG_0;
            4'd1:    seg_n_o = SEG_1;
            4'd2:    seg_n_o = SEG_2;
            4'd3:    seg_n_o = SEG_3;
            4'd4:    seg_n_o = SEG_4;
            4'd5:    seg_n_o = SEG_5;
            4'd6:    seg_n_o = SEG_6;
            4'd7:    seg_n_o = SEG_7;
            4'd8:    seg_n_o = SEG_8;
            4'd9:    seg_n_o = SEG_9;
            default: seg_n_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_seg_scan.sv
// ----------------------------------------------------------------------------
// bcd_seg_scan
// Time-multiplexed driver for a 3-digit common-anode 7-segment display.
// Incoming values are held in a pending register and copied into the display
// register only at the end of a full scan (frame), so a frame never mixes
// digits from two different values.
//   clk              system clock
//   rst              asynchronous, active-high reset
//   bus (slave)      bcd_in / bcd_valid in; seg_n / dig_sel_n / frame_done out
// Parameters:
//   SCAN_DIV  clock cycles per digit slot (>= 2)
//   GUARD     dark cycles at the start of each slot (0 .. SCAN_DIV-1)
//   BLANK_LZ  1 = blank leading zeros, 0 = always show all three digits
// ----------------------------------------------------------------------------
module bcd_seg_scan
    import bcd_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned GUARD    = 16,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    bcd_seg_scan_if.slave  bus
);

    localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_q,      presc_d;
    digit_e        digit_q,      digit_d;
    logic [11:0]   pending_q,    pending_d;
    logic          pend_flag_q,  pend_flag_d;
    logic [11:0]   disp_q,       disp_d;
    logic [6:0]    seg_q,        seg_d;
    logic [2:0]    sel_q,        sel_d;
    logic          frame_done_q, frame_done_d;

    logic          slot_end;
    logic          frame_end;
    logic [3:0]    nibble;
    logic [2:0]    sel_onehot;
    logic          blank;
    logic          lit;
    logic [6:0]    seg_dec;

    assign slot_end  = (presc_q == PW'(SCAN_DIV - 1));
    assign frame_end = slot_end && (digit_q == D2);

    // ------------------------------------------------------------------
    // Digit FSM: state register
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q <= D0;
        end else begin
            digit_q <= digit_d;
        end
    end

    // Digit FSM: next state. Ring of three slots with no idle state.
    // NOTE: the default assignment first keeps every path assigned, so no
    // latch is inferred when a case arm is missed.
    always_comb begin
        digit_d = digit_q;
        if (slot_end) begin
            case (digit_q)
                D0:      digit_d = D1;
                D1:      digit_d = D2;
                default: digit_d = D0;
            endcase
        end
    end

    // Digit FSM: outputs (selected nibble and its enable bit).
    always_comb begin
        nibble     = disp_q[3:0];
        sel_onehot = 3'b001;
        case (digit_q)
            D1: begin
                nibble     = disp_q[7:4];
                sel_onehot = 3'b010;
            end
            D2: begin
                nibble     = disp_q[11:8];
                sel_onehot = 3'b100;
            end
            default: begin
                nibble     = disp_q[3:0];
                sel_onehot = 3'b001;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Prescaler and value registers
    // ------------------------------------------------------------------
    always_comb begin
        presc_d     = slot_end ? '0 : presc_q + 1'b1;
        pending_d   = pending_q;
        pend_flag_d = pend_flag_q;
        disp_d      = disp_q;

        if (frame_end) begin
            // A strobe landing on the boundary is newer than anything
            // pending, so it goes straight to the display.
            if (bus.bcd_valid) begin
                disp_d = bus.bcd_in;
            end else if (pend_flag_q) begin
                disp_d = pending_q;
            end
            pend_flag_d = 1'b0;
        end else if (bus.bcd_valid) begin
            pending_d   = bus.bcd_in;
            pend_flag_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Pin drive: decoded from the current state, registered one cycle late
    // so the pins are glitch-free.
    // ------------------------------------------------------------------
    bcd_to_seg7 u_dec (
        .nibble_i (nibble),
        .seg_n_o  (seg_dec)
    );

    always_comb begin
        blank        = BLANK_LZ && lz_blank(disp_q[11:8], disp_q[7:4], digit_q);
        // Dark guard at the start of each slot hides the previous digit's
        // pattern while the anode drivers switch over (anti-ghosting).
        lit          = (presc_q >= PW'(GUARD)) && !blank;
        seg_d        = lit ? seg_dec : SEG_OFF;
        sel_d        = lit ? ~sel_onehot : 3'b111;
        frame_done_d = frame_end;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q      <= '0;
            pending_q    <= '0;
            pend_flag_q  <= 1'b0;
            disp_q       <= '0;
            seg_q        <= SEG_OFF;
            sel_q        <= 3'b111;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            pending_q    <= pending_d;
            pend_flag_q  <= pend_flag_d;
            disp_q       <= disp_d;
            seg_q        <= seg_d;
            sel_q        <= sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.seg_n      = seg_q;
    assign bus.dig_sel_n  = sel_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// ----------------------------------------------------------------------------
// tb_bcd_seg_scan
// Directed bench for bcd_seg_scan with SCAN_DIV = 8 and GUARD = 2. Two DUTs
// run in lockstep on the same stimulus: dut_a blanks leading zeros, dut_b
// does not. Pins are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_bcd_seg_scan;
    import bcd_disp_pkg::*;

    localparam int SD = 8;
    localparam int GD = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bcd_seg_scan_if bus_a ();
    bcd_seg_scan_if bus_b ();

    bcd_seg_scan #(.SCAN_DIV(SD), .GUARD(GD), .BLANK_LZ(1'b1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    bcd_seg_scan #(.SCAN_DIV(SD), .GUARD(GD), .BLANK_LZ(1'b0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [11:0] val);
        bus_a.bcd_valid = v;
        bus_a.bcd_in    = val;
        bus_b.bcd_valid = v;
        bus_b.bcd_in    = val;
    endtask

    task automatic check_reset(input string tag);
        check({tag, " seg"}, {1'b0, bus_a.seg_n},      8'h7F);
        check({tag, " sel"}, {5'b0, bus_a.dig_sel_n},  8'h07);
        check({tag, " fd"},  {7'b0, bus_a.frame_done}, 8'h00);
        check({tag, " seg_b"}, {1'b0, bus_b.seg_n},    8'h7F);
    endtask

    // Checks the 24 pin samples of one frame. Sample i (1..24) reflects
    // prescaler (i-1)%8 of slot (i-1)/8; frame_done must be high on sample
    // 24 only. A strobe can be injected before sample inj1 / inj2.
    task automatic check_frame(input bit use_b,
                               input logic [6:0] s0, input logic [2:0] d0,
                               input logic [6:0] s1, input logic [2:0] d1,
                               input logic [6:0] s2, input logic [2:0] d2,
                               input int inj1, input logic [11:0] v1,
                               input int inj2, input logic [11:0] v2,
                               input string tag);
        int         slot;
        int         p;
        logic [6:0] es;
        logic [2:0] ed;
        logic [6:0] os;
        logic [2:0] od;
        logic       ofd;
        for (int i = 1; i <= 3 * SD; i++) begin
            if (i == inj1)      drive(1'b1, v1);
            else if (i == inj2) drive(1'b1, v2);
            else                drive(1'b0, 12'h000);
            @(negedge clk);
            slot = (i - 1) / SD;
            p    = (i - 1) % SD;
            if (p < GD) begin
                es = 7'h7F;
                ed = 3'b111;
            end else if (slot == 0) begin
                es = s0;
                ed = d0;
            end else if (slot == 1) begin
                es = s1;
                ed = d1;
            end else begin
                es = s2;
                ed = d2;
            end
            os  = use_b ? bus_b.seg_n      : bus_a.seg_n;
            od  = use_b ? bus_b.dig_sel_n  : bus_a.dig_sel_n;
            ofd = use_b ? bus_b.frame_done : bus_a.frame_done;
            check($sformatf("%s seg c%0d", tag, i), {1'b0, os}, {1'b0, es});
            check($sformatf("%s sel c%0d", tag, i), {5'b0, od}, {5'b0, ed});
            check($sformatf("%s fd c%0d", tag, i), {7'b0, ofd}, {7'b0, (i == 3 * SD)});
        end
        drive(1'b0, 12'h000);
    endtask

    initial begin
        drive(1'b0, 12'h000);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_reset("reset");
        end
        rst = 1'b0;

        // First frame after release: display still 000, capture 123.
        check_frame(1'b0, 7'h40, 3'b110, 7'h7F, 3'b111, 7'h7F, 3'b111,
                    3, 12'h123, 0, 12'h000, "init");
        // 123 shown; queue 007.
        check_frame(1'b0, 7'h30, 3'b110, 7'h24, 3'b101, 7'h79, 3'b011,
                    1, 12'h007, 0, 12'h000, "v123");
        // Leading-zero blanking on 007.
        check_frame(1'b0, 7'h78, 3'b110, 7'h7F, 3'b111, 7'h7F, 3'b111,
                    0, 12'h000, 0, 12'h000, "v007");
        // Same value, no blanking; queue 000.
        check_frame(1'b1, 7'h78, 3'b110, 7'h40, 3'b101, 7'h40, 3'b011,
                    1, 12'h000, 0, 12'h000, "v007_nolz");
        // 000 shows a single zero; queue 090.
        check_frame(1'b0, 7'h40, 3'b110, 7'h7F, 3'b111, 7'h7F, 3'b111,
                    1, 12'h090, 0, 12'h000, "v000");
        // 090 stays intact while 456 then 789 arrive mid-frame.
        check_frame(1'b0, 7'h40, 3'b110, 7'h10, 3'b101, 7'h7F, 3'b111,
                    5, 12'h456, 12, 12'h789, "v090");
        // Last write wins: 789. Strobe 250 exactly on the boundary.
        check_frame(1'b0, 7'h10, 3'b110, 7'h00, 3'b101, 7'h78, 3'b011,
                    24, 12'h250, 0, 12'h000, "v789");
        // Boundary strobe shows in the very next frame.
        check_frame(1'b0, 7'h40, 3'b110, 7'h12, 3'b101, 7'h24, 3'b011,
                    0, 12'h000, 0, 12'h000, "v250");
        // Nothing stale pending; queue 1A3.
        check_frame(1'b0, 7'h40, 3'b110, 7'h12, 3'b101, 7'h24, 3'b011,
                    1, 12'h1A3, 0, 12'h000, "v250_hold");
        // Invalid tens nibble shows a dash and is not blanked.
        check_frame(1'b0, 7'h30, 3'b110, 7'h3F, 3'b101, 7'h79, 3'b011,
                    0, 12'h000, 0, 12'h000, "v1A3");

        // Reset while the tens slot is lit.
        repeat (12) @(negedge clk);
        check("mid tens sel", {5'b0, bus_a.dig_sel_n}, 8'h05);
        check("mid tens seg", {1'b0, bus_a.seg_n},     8'h3F);
        rst = 1'b1;
        #1;
        check_reset("rst_async");
        repeat (2) @(negedge clk);
        check_reset("rst_hold");
        rst = 1'b0;

        // Display cleared; scan restarts at D0 cycle 0, frame_done after 24.
        check_frame(1'b0, 7'h40, 3'b110, 7'h7F, 3'b111, 7'h7F, 3'b111,
                    0, 12'h000, 0, 12'h000, "post_rst");
        check_frame(1'b0, 7'h40, 3'b110, 7'h7F, 3'b111, 7'h7F, 3'b111,
                    0, 12'h000, 0, 12'h000, "post_rst2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
